// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive deframer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_e;

  localparam int unsigned OversampleRate = 16;
  localparam int unsigned MidBitTick     = 7;

  // Clock cycles per oversample tick, rounded down.
  function automatic int unsigned divisor(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OversampleRate);
  endfunction

  // Even parity bit over one data byte.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with wrap-bit pointers; an overflowing push is dropped and flagged.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   fill_o,
  output logic                     overrun_o
);

  localparam int unsigned PtrW  = $clog2(Depth) + 1;
  localparam int unsigned AddrW = PtrW - 1;

  logic [7:0]      mem_q [Depth];
  logic [7:0]      mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            overrun_q, overrun_d;
  logic            full_s, empty_s, pop_s, wr_en_s;

  // Pointer, storage and overrun next-state; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    full_s    = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    empty_s   = (wr_ptr_q == rd_ptr_q);
    pop_s     = pop_i && !empty_s;
    wr_en_s   = push_i && (!full_s || pop_s);
    overrun_d = push_i && full_s && !pop_s;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = push_data_i;
      wr_ptr_d                   = wr_ptr_q + PtrW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = mem_q[rd_ptr_q[AddrW-1:0]];
  assign valid_o   = !empty_s;
  assign fill_o    = wr_ptr_q - rd_ptr_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x-oversampling UART receiver: synchronizer, tick generator, framing FSM and byte FIFO.
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int unsigned ClkFrequency = 20_000_000,
  parameter int unsigned BaudRate     = 115200,
  parameter bit          ParityEna    = 1'b0,
  parameter int unsigned FifoDepth    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  output logic [7:0]                   data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(FifoDepth):0]   fill_o,
  output logic                         frame_err_o,
  output logic                         parity_err_o,
  output logic                         overrun_o
);

  localparam int unsigned Divisor = divisor(ClkFrequency, BaudRate);
  localparam int unsigned CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;

  logic            sync_meta_q, sync_meta_d;
  logic            rx_s_q, rx_s_d;
  logic            rx_q, rx_d;
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  uart_rx_state_e  state_q, state_d;
  logic [3:0]      sample_cnt_q, sample_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            par_err_q, par_err_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            tick_s, start_frame_s, push_s;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; tick counter restarts with each frame.
  always_comb begin
    sync_meta_d = rx_i;
    rx_s_d      = sync_meta_q;
    rx_d        = rx_s_q;
    tick_s      = (tick_cnt_q == CntW'(Divisor - 1));
    if (start_frame_s || tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CntW'(1);
    end
  end

  // Frame FSM: mid-start-bit glitch filter, then one sample per 16 ticks for data, parity and stop.
  always_comb begin
    state_d       = state_q;
    sample_cnt_d  = sample_cnt_q;
    bit_idx_d     = bit_idx_q;
    data_d        = data_q;
    par_err_d     = par_err_q;
    frame_err_d   = 1'b0;
    parity_err_d  = 1'b0;
    push_s        = 1'b0;
    start_frame_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_q && !rx_s_q) begin
          state_d       = START;
          start_frame_s = 1'b1;
          sample_cnt_d  = 4'd0;
          bit_idx_d     = 3'd0;
          par_err_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          if (sample_cnt_q == 4'(MidBitTick)) begin
            sample_cnt_d = 4'd0;
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      DATA: begin
        if (tick_s) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            data_d[bit_idx_q] = rx_s_q;
            bit_idx_d         = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = ParityEna ? PARITY : STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      PARITY: begin
        if (tick_s) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
          if (sample_cnt_q == 4'd15) begin
            par_err_d = (rx_s_q != even_parity(data_q));
            state_d   = STOP;
          end else begin
            state_d = PARITY;
          end
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      STOP: begin
        if (tick_s && (sample_cnt_q == 4'd15)) begin
          state_d = IDLE;
          if (!rx_s_q) begin
            frame_err_d  = 1'b1;
            parity_err_d = par_err_q;
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
          end else begin
            push_s = 1'b1;
          end
        end else if (tick_s) begin
          sample_cnt_d = sample_cnt_q + 4'd1;
        end else begin
          sample_cnt_d = sample_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Receiver state registers; the line-side flops reset to the idle-high level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta_q  <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_q         <= 1'b1;
      tick_cnt_q   <= '0;
      state_q      <= IDLE;
      sample_cnt_q <= 4'd0;
      bit_idx_q    <= 3'd0;
      data_q       <= 8'h00;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync_meta_q  <= sync_meta_d;
      rx_s_q       <= rx_s_d;
      rx_q         <= rx_d;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_q       <= data_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  uart_rx_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push_s),
    .push_data_i (data_q),
    .pop_i       (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .fill_o      (fill_o),
    .overrun_o   (overrun_o)
  );

  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule
